// File: rtl/z80_ld_ixiy_nn_exec.sv
// Executes LD IX,nn / LD IY,nn (DD/FD 21 lo hi), fetching one byte per read handshake.
// Define Z80FI_EN to add the Z80FI retirement port and its capture registers.
module z80_ld_ixiy_nn_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ip_load,
  input  logic [15:0] ip_load_value,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [15:0] ip,
  output logic [15:0] ix,
  output logic [15:0] iy
`ifdef Z80FI_EN
  ,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_reg_ip_in,
  output logic [15:0] z80fi_reg_ip_out,
  output logic [15:0] z80fi_reg_ix_in,
  output logic [15:0] z80fi_reg_ix_out,
  output logic [15:0] z80fi_reg_iy_in,
  output logic [15:0] z80fi_reg_iy_out
`endif
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, RETIRE, FAULT} state_t;

  state_t      state, state_nxt;
  logic [15:0] ip_snap, ip_snap_nxt;
  logic [15:0] fetch_addr;
  logic [15:0] nn;
  logic        sel_iy, sel_iy_nxt;
  logic        fetch_nxt;
  logic [7:0]  lo_byte;
  logic        f3_ack;

  assign busy   = (state != IDLE);
  assign f3_ack = (state == F3) && mem_ack;
  assign nn     = {mem_data, lo_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ip_snap_nxt = ip_snap;
    sel_iy_nxt  = sel_iy;
    case (state)
      IDLE: if (start) begin
        state_nxt   = F0;
        ip_snap_nxt = ip_load ? ip_load_value : ip;
      end
      F0: if (mem_ack) begin
        if (mem_data == 8'hDD) begin
          state_nxt  = F1;
          sel_iy_nxt = 1'b0;
        end else if (mem_data == 8'hFD) begin
          state_nxt  = F1;
          sel_iy_nxt = 1'b1;
        end else begin
          state_nxt  = FAULT;
        end
      end
      F1:      if (mem_ack) state_nxt = (mem_data == 8'h21) ? F2 : FAULT;
      F2:      if (mem_ack) state_nxt = F3;
      F3:      if (mem_ack) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and read strobe are registered, so they are computed for the state being entered.
  always_comb begin
    fetch_addr = mem_addr;
    fetch_nxt  = 1'b1;
    case (state_nxt)
      F0:      fetch_addr = ip_snap_nxt;
      F1:      fetch_addr = ip_snap_nxt + 16'd1;
      F2:      fetch_addr = ip_snap_nxt + 16'd2;
      F3:      fetch_addr = ip_snap_nxt + 16'd3;
      default: fetch_nxt  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd   <= 1'b0;
      mem_addr <= 16'h0000;
      done     <= 1'b0;
      fault    <= 1'b0;
      ip       <= 16'h0000;
      ix       <= 16'h0000;
      iy       <= 16'h0000;
      ip_snap  <= 16'h0000;
      sel_iy   <= 1'b0;
      lo_byte  <= 8'h00;
    end else begin
      mem_rd   <= fetch_nxt;
      mem_addr <= fetch_addr;
      done     <= (state_nxt == RETIRE);
      fault    <= (state_nxt == FAULT);
      ip_snap  <= ip_snap_nxt;
      sel_iy   <= sel_iy_nxt;
      if (state == IDLE && ip_load) ip <= ip_load_value;
      if (state == F2 && mem_ack) lo_byte <= mem_data;
      if (f3_ack) begin
        ip <= ip_snap + 16'd4;
        if (sel_iy) iy <= nn;
        else        ix <= nn;
      end
    end
  end

`ifdef Z80FI_EN
  logic [15:0] ix_snap, iy_snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ix_snap          <= 16'h0000;
      iy_snap          <= 16'h0000;
      z80fi_valid      <= 1'b0;
      z80fi_insn       <= 32'h0000_0000;
      z80fi_insn_len   <= 4'd0;
      z80fi_reg_ip_in  <= 16'h0000;
      z80fi_reg_ip_out <= 16'h0000;
      z80fi_reg_ix_in  <= 16'h0000;
      z80fi_reg_ix_out <= 16'h0000;
      z80fi_reg_iy_in  <= 16'h0000;
      z80fi_reg_iy_out <= 16'h0000;
    end else begin
      z80fi_valid <= (state_nxt == RETIRE);
      if (state == IDLE && start) begin
        ix_snap <= ix;
        iy_snap <= iy;
      end
      if (mem_ack) begin
        case (state)
          F0:      z80fi_insn[7:0]   <= mem_data;
          F1:      z80fi_insn[15:8]  <= mem_data;
          F2:      z80fi_insn[23:16] <= mem_data;
          F3:      z80fi_insn[31:24] <= mem_data;
          default: ;
        endcase
      end
      // Retirement record is published together with the architectural update.
      if (f3_ack) begin
        z80fi_insn_len   <= 4'd4;
        z80fi_reg_ip_in  <= ip_snap;
        z80fi_reg_ix_in  <= ix_snap;
        z80fi_reg_iy_in  <= iy_snap;
        z80fi_reg_ip_out <= ip_snap + 16'd4;
        z80fi_reg_ix_out <= sel_iy ? ix : nn;
        z80fi_reg_iy_out <= sel_iy ? nn : iy;
      end
    end
  end
`endif

endmodule

// File: tb/tb_z80_ld_ixiy_nn_exec.sv
// Bench for z80_ld_ixiy_nn_exec: scripted memory responder plus expected-result and address scoreboards.
module tb_z80_ld_ixiy_nn_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ip_load = 1'b0;
  logic [15:0] ip_load_value = 16'h0000;
  logic        busy, done, fault, mem_rd;
  logic [15:0] mem_addr, ip, ix, iy;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_ack = 1'b0;
`ifdef Z80FI_EN
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [3:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_ix_in;
  logic [15:0] z80fi_reg_ix_out, z80fi_reg_iy_in, z80fi_reg_iy_out;
`endif

  z80_ld_ixiy_nn_exec dut (
    .clk(clk), .reset(reset), .start(start), .ip_load(ip_load),
    .ip_load_value(ip_load_value), .busy(busy), .done(done), .fault(fault),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
    .ip(ip), .ix(ix), .iy(iy)
`ifdef Z80FI_EN
    , .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
    .z80fi_reg_ix_in(z80fi_reg_ix_in), .z80fi_reg_ix_out(z80fi_reg_ix_out),
    .z80fi_reg_iy_in(z80fi_reg_iy_in), .z80fi_reg_iy_out(z80fi_reg_iy_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    int          cyc;
    logic [15:0] ip_in;
    logic [15:0] ip;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [31:0] insn;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  mem [0:65535];
  int          waits = 0;
  int          wcnt = 0;
  int          errors = 0;
  int          checks = 0;

  // Memory responder: acks after 'waits' idle cycles and checks each acked address.
  always @(negedge clk) begin
    if (reset || !mem_rd) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt == waits) begin
      mem_ack = 1'b1;
      mem_data = mem[mem_addr];
      wcnt = 0;
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: addr=%h, no read expected", mem_addr);
      end else begin
        logic [15:0] ea;
        ea = addr_q.pop_front();
        if (mem_addr !== ea) begin
          errors++;
          $display("FAIL read_addr: got %h expected %h", mem_addr, ea);
        end
      end
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  task automatic load_ip(input logic [15:0] v);
    ip_load = 1'b1;
    ip_load_value = v;
    @(negedge clk);
    ip_load = 1'b0;
  endtask

  task automatic put4(input logic [15:0] a, input logic [31:0] bytes);
    for (int k = 0; k < 4; k++) begin
      mem[a + 16'(k)] = bytes[8*k +: 8];
    end
  endtask

  task automatic run_insn(input string name, input bit with_load, input logic [15:0] load_val,
                          input bit poke);
    exp_t e;
    int   cyc;
    start = 1'b1;
    ip_load = with_load;
    ip_load_value = load_val;
    @(negedge clk);
    start = 1'b0;
    ip_load = 1'b0;
    cyc = 1;
    while (!(done || fault) && cyc < 200) begin
      if (poke && cyc == 2) begin
        start = 1'b1; ip_load = 1'b1; ip_load_value = 16'h9999;
      end else begin
        start = 1'b0; ip_load = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ip_load = 1'b0;
    checks++;
    if (cyc >= 200 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: cycles=%0d pending=%0d", name, cyc, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (fault !== e.is_fault || done !== !e.is_fault) begin
      errors++;
      $display("FAIL %s_kind: done=%b fault=%b expected fault=%b", name, done, fault, e.is_fault);
    end
    checks++;
    if (cyc !== e.cyc) begin
      errors++;
      $display("FAIL %s_latency: cycle %0d expected %0d", name, cyc, e.cyc);
    end
    checks++;
    if (ip !== e.ip || ix !== e.ix || iy !== e.iy) begin
      errors++;
      $display("FAIL %s_regs: ip=%h ix=%h iy=%h expected %h %h %h", name, ip, ix, iy, e.ip, e.ix, e.iy);
    end
`ifdef Z80FI_EN
    checks++;
    if (z80fi_valid !== !e.is_fault) begin
      errors++;
      $display("FAIL %s_z80fi_valid: got %b expected %b", name, z80fi_valid, !e.is_fault);
    end
    if (!e.is_fault) begin
      checks++;
      if (z80fi_insn !== e.insn || z80fi_insn_len !== 4'd4) begin
        errors++;
        $display("FAIL %s_z80fi_insn: got %h len %0d expected %h len 4", name, z80fi_insn,
                 z80fi_insn_len, e.insn);
      end
      checks++;
      if (z80fi_reg_ip_in !== e.ip_in || z80fi_reg_ip_out !== e.ip ||
          z80fi_reg_ix_out !== e.ix || z80fi_reg_iy_out !== e.iy) begin
        errors++;
        $display("FAIL %s_z80fi_regs: ip_in=%h ip_out=%h ix_out=%h iy_out=%h expected %h %h %h %h",
                 name, z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_ix_out, z80fi_reg_iy_out,
                 e.ip_in, e.ip, e.ix, e.iy);
      end
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_end: done=%b fault=%b busy=%b expected 0 0 0", name, done, fault, busy);
    end
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_reads_missing: %0d reads outstanding, expected 0", name, addr_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (ip !== 16'h0 || ix !== 16'h0 || iy !== 16'h0 || mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: ip=%h ix=%h iy=%h addr=%h expected 0000", ip, ix, iy, mem_addr);
    end
    checks++;
    if (mem_rd !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd=%b done=%b fault=%b busy=%b expected 0", mem_rd, done, fault, busy);
    end
`ifdef Z80FI_EN
    checks++;
    if (z80fi_valid !== 1'b0 || z80fi_insn !== 32'h0 || z80fi_reg_ip_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_z80fi: valid=%b insn=%h ip_out=%h expected 0", z80fi_valid, z80fi_insn,
               z80fi_reg_ip_out);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ld_ix;
    load_ip(16'h1000);
    checks++;
    if (ip !== 16'h1000) begin
      errors++;
      $display("FAIL ip_load: got %h expected 1000", ip);
    end
    waits = 0;
    put4(16'h1000, 32'h1234_21DD);
    for (int k = 0; k < 4; k++) addr_q.push_back(16'h1000 + 16'(k));
    exp_q.push_back('{1'b0, 5, 16'h1000, 16'h1004, 16'h1234, 16'h0000, 32'h1234_21DD});
    run_insn("ld_ix", 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_ld_iy_wrap;
    load_ip(16'hFFFE);
    waits = 2;
    put4(16'hFFFE, 32'hABCD_21FD);
    addr_q.push_back(16'hFFFE); addr_q.push_back(16'hFFFF);
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0001);
    exp_q.push_back('{1'b0, 13, 16'hFFFE, 16'h0002, 16'h1234, 16'hABCD, 32'hABCD_21FD});
    run_insn("ld_iy_wrap", 1'b0, 16'h0, 1'b0);
    waits = 0;
  endtask

  task automatic test_fault;
    load_ip(16'h2000);
    mem[16'h2000] = 8'hED;
    addr_q.push_back(16'h2000);
    exp_q.push_back('{1'b1, 2, 16'h2000, 16'h2000, 16'h1234, 16'hABCD, 32'h0});
    run_insn("fault_byte0", 1'b0, 16'h0, 1'b0);
    mem[16'h2000] = 8'hDD;
    mem[16'h2001] = 8'h22;
    addr_q.push_back(16'h2000); addr_q.push_back(16'h2001);
    exp_q.push_back('{1'b1, 3, 16'h2000, 16'h2000, 16'h1234, 16'hABCD, 32'h0});
    run_insn("fault_byte1", 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch;
    bit saw_done;
    load_ip(16'h3000);
    waits = 1;
    put4(16'h3000, 32'h5678_21DD);
    addr_q.push_back(16'h3000); addr_q.push_back(16'h3001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || saw_done) begin
      errors++;
      $display("FAIL reset_mid_ctrl: rd=%b busy=%b done=%b early_done=%b expected 0", mem_rd, busy,
               done, saw_done);
    end
    checks++;
    if (ip !== 16'h0 || ix !== 16'h0 || iy !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_regs: ip=%h ix=%h iy=%h expected 0000", ip, ix, iy);
    end
    addr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    waits = 0;
    @(negedge clk);
    load_ip(16'h3000);
    for (int k = 0; k < 4; k++) addr_q.push_back(16'h3000 + 16'(k));
    exp_q.push_back('{1'b0, 5, 16'h3000, 16'h3004, 16'h5678, 16'h0000, 32'h5678_21DD});
    run_insn("after_reset", 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    put4(16'h4000, 32'h2211_21FD);
    put4(16'h4004, 32'hBEEF_21DD);
    for (int k = 0; k < 4; k++) addr_q.push_back(16'h4000 + 16'(k));
    exp_q.push_back('{1'b0, 5, 16'h4000, 16'h4004, 16'h5678, 16'h2211, 32'h2211_21FD});
    run_insn("load_start_poke", 1'b1, 16'h4000, 1'b1);
    for (int k = 0; k < 4; k++) addr_q.push_back(16'h4004 + 16'(k));
    exp_q.push_back('{1'b0, 5, 16'h4004, 16'h4008, 16'hBEEF, 16'h2211, 32'hBEEF_21DD});
    run_insn("back_to_back", 1'b0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ip !== 16'h4008) begin
      errors++;
      $display("FAIL idle_after: busy=%b ip=%h expected 0 4008", busy, ip);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_ld_ix();
    test_ld_iy_wrap();
    test_fault();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z80_ld_ixiy_nn_exec.md
# z80_ld_ixiy_nn_exec

Executes the 4-byte `LD IX,nn` / `LD IY,nn` instruction (DD/FD 21 lo hi) by fetching it byte by byte over the core's memory read handshake. It owns the architectural IP, IX and IY registers for this path. It retires the instruction on the Z80FI retirement port, so the formal instruction specs can check the result. It sits between the sequencer, which issues `start`, and the memory bus.

## Interface
Parameters: none.

- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin executing at current `ip`; sampled only in IDLE.
- `ip_load` in 1: load `ip` from `ip_load_value`; sampled only in IDLE.
- `ip_load_value` in 16: new IP.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful retire.
- `fault` out 1: one-cycle pulse on bad opcode; no architectural change.
- `mem_addr` out 16: byte address.
- `mem_rd` out 1: read request.
- `mem_data` in 8: read data; valid when `mem_ack` is high.
- `mem_ack` in 1: read complete; may be high in the same cycle as `mem_rd`.
- `ip`, `ix`, `iy` out 16 each: architectural registers.
- `z80fi_valid` out 1: retirement pulse (macro-gated).
- `z80fi_insn` out 32: fetched bytes (macro-gated).
- `z80fi_insn_len` out 4: instruction length (macro-gated).
- `z80fi_reg_{ip,ix,iy}_{in,out}` out 16 each: pre- and post-instruction register values (macro-gated).

## Operation
- States: IDLE, F0, F1, F2, F3, RETIRE, FAULT.
- IDLE:
  - `ip_load` sets `ip` to `ip_load_value` on the clock edge.
  - `start` moves to F0 and snapshots `ip`, `ix` and `iy` into the *_in copies.
  - If both are high, both act, and the fetch uses the newly loaded `ip`.
- Fk (k=0..3):
  - `mem_rd` is 1 and `mem_addr` is `ip_snap + k`, modulo 2^16, so FFFE wraps to FFFF, 0000, 0001.
  - The state holds until `mem_ack`; on the `mem_ack` edge, `mem_data` is latched into `z80fi_insn[8k+7:8k]`.
- F0 ack: byte must be DD (selects IX) or FD (selects IY); any other byte goes to FAULT.
- F1 ack: byte must be 21, else FAULT.
- F3 ack edge:
  - nn = {byte3, byte2}, i.e. `z80fi_insn[31:16]`, little-endian.
  - DD writes nn to `ix`; FD writes nn to `iy`; the other register is unchanged.
  - `ip` becomes `ip_snap + 4`, modulo 2^16.
  - Next state is RETIRE.
- RETIRE: `done` is 1 for exactly one cycle, then IDLE.
- FAULT:
  - `fault` is 1 for one cycle, then IDLE.
  - `ip`, `ix` and `iy` are unchanged.
  - No further bytes are fetched after the failing byte.
- `start` and `ip_load` are ignored while `busy`. No queuing.
- Reset values:
  - State is IDLE.
  - `ip`, `ix`, `iy`, `mem_addr`, all *_in/*_out and `z80fi_insn` are 0000.
  - `mem_rd`, `done`, `fault` and `z80fi_valid` are 0.
- Reset mid-fetch: immediately IDLE, `mem_rd` deasserted; a partial instruction leaves no effect.

## Timing
- All outputs are registered except `busy`, which is decoded from state.
- Zero-wait memory (`mem_ack` high whenever `mem_rd` is high):
  - `start` is sampled at edge 0.
  - `mem_rd` is high in cycles 1–4.
  - `ix`/`iy`/`ip` update at edge 4.
  - `done` is high in cycle 5.
  - Minimum start-to-done is 5 cycles; each wait cycle adds 1.
- Fault on byte 0 with zero wait: `fault` is high in cycle 2, and `ip` is untouched.
- `start` is accepted again in the first IDLE cycle after `done` or `fault`, which gives a 6-cycle minimum issue interval.

## Configuration
- `Z80FI_EN` defined:
  - In RETIRE, `z80fi_valid` is 1.
  - `z80fi_insn_len` is 4.
  - `z80fi_reg_*_in` hold the snapshot and `z80fi_reg_*_out` hold the updated values.
  - Outside RETIRE, `z80fi_valid` is 0, and `insn_len` and the reg ports keep their last values.
  - FAULT never raises `z80fi_valid`.
- `Z80FI_EN` undefined:
  - All `z80fi_*` ports and their capture/snapshot registers are removed.
  - Architectural behaviour and timing are identical.

## Test plan
- Reset, load `ip`=1000, start, zero-wait memory returning DD 21 34 12 → `ix`=1234, `iy` unchanged, `ip`=1004, `done` in cycle 5, `z80fi_insn`=1234_21DD, `z80fi_insn_len`=4.
- `ip`=FFFE, memory FD 21 CD AB with 2 wait cycles per byte → addresses FFFE, FFFF, 0000, 0001; `iy`=ABCD, `ip`=0002, `done` at cycle 13.
- Byte0=ED → `fault` in cycle 2, only one `mem_rd` address issued, registers unchanged, `z80fi_valid` never high.
- Byte0=DD, byte1=22 → `fault` after F1 ack, `ix` unchanged, `ip` unchanged.
- Assert `reset` during F2 → outputs reach reset values immediately, `mem_rd`=0, no `done`; a subsequent run completes normally.
- `start` pulsed while `busy`, and `ip_load`+`start` together in IDLE → busy `start` is ignored; the combined case fetches from `ip_load_value`.
